// File: rtl/persp_div_i18.sv
// Perspective divide: x/w, y/w, z/w as signed fixed-point with saturation,
// using three radix-2 restoring dividers that share one iteration counter.
module persp_div_i18 #(
    parameter int FRAC_BITS = 8,
    parameter int OUT_W     = 16
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic             i_valid,
    input  logic [17:0]      i_res0,
    input  logic [17:0]      i_res1,
    input  logic [17:0]      i_res2,
    input  logic [17:0]      i_res3,
    output logic             o_ready,
    output logic             o_valid,
    input  logic             i_accept,
    output logic [OUT_W-1:0] o_x,
    output logic [OUT_W-1:0] o_y,
    output logic [OUT_W-1:0] o_z,
    output logic             o_div_zero
);

    localparam int QW = 18 + FRAC_BITS;
    localparam int CW = $clog2(QW);

    localparam logic [QW-1:0]    MAXP  = {{(QW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic [QW-1:0]    MINM  = MAXP + {{(QW-1){1'b0}}, 1'b1};
    localparam logic [OUT_W-1:0] O_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] O_MIN = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] O_ONE = {{(OUT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, DIV, SAT, OUT} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [2:0][QW-1:0]   acc;      // dividend shifts out the top, quotient shifts in the bottom
    logic [2:0][18:0]     rem;
    logic [2:0][QW-1:0]   acc_nx;
    logic [2:0][18:0]     rem_nx;
    logic [2:0][18:0]     sh;
    logic [2:0]           sn;
    logic [2:0]           nz;
    logic                 sw;
    logic                 zf;
    logic [17:0]          mag_w;
    logic [2:0][17:0]     nin;

    assign nin     = {i_res2, i_res1, i_res0};
    assign o_ready = (state == IDLE);

    function automatic logic [17:0] abs18(input logic [17:0] v);
        return v[17] ? (~v + 18'd1) : v;
    endfunction

    function automatic logic [OUT_W-1:0] lane_out(input logic neg, input logic nzv,
                                                  input logic zflag, input logic [QW-1:0] q);
        logic [OUT_W-1:0] t;
        t = q[OUT_W-1:0];
        if (zflag)
            return !nzv ? '0 : (neg ? O_MIN : O_MAX);
        else if (!neg)
            return (q > MAXP) ? O_MAX : t;
        else
            return (q > MINM) ? O_MIN : (~t + O_ONE);
    endfunction

    always_comb begin
        sh     = '0;
        rem_nx = '0;
        acc_nx = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            sh[i] = {rem[i][17:0], acc[i][QW-1]};
            if (sh[i] >= {1'b0, mag_w}) begin
                rem_nx[i] = sh[i] - {1'b0, mag_w};
                acc_nx[i] = {acc[i][QW-2:0], 1'b1};
            end else begin
                rem_nx[i] = sh[i];
                acc_nx[i] = {acc[i][QW-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state      <= IDLE;
            cnt        <= '0;
            acc        <= '0;
            rem        <= '0;
            sn         <= '0;
            nz         <= '0;
            sw         <= 1'b0;
            zf         <= 1'b0;
            mag_w      <= '0;
            o_valid    <= 1'b0;
            o_x        <= '0;
            o_y        <= '0;
            o_z        <= '0;
            o_div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        for (int unsigned i = 0; i < 3; i++) begin
                            acc[i] <= {abs18(nin[i]), {FRAC_BITS{1'b0}}};
                            rem[i] <= '0;
                            sn[i]  <= nin[i][17];
                            nz[i]  <= |nin[i];
                        end
                        sw    <= i_res3[17];
                        mag_w <= abs18(i_res3);
                        zf    <= (i_res3 == '0);
                        cnt   <= CW'(QW - 1);
                        state <= (i_res3 == '0) ? SAT : DIV;
                    end
                end
                DIV: begin
                    acc <= acc_nx;
                    rem <= rem_nx;
                    cnt <= cnt - CW'(1);
                    if (cnt == '0)
                        state <= SAT;
                end
                SAT: begin
                    // with w==0 only the numerator sign decides the clamp direction
                    o_x        <= lane_out(zf ? sn[0] : sn[0] ^ sw, nz[0], zf, acc[0]);
                    o_y        <= lane_out(zf ? sn[1] : sn[1] ^ sw, nz[1], zf, acc[1]);
                    o_z        <= lane_out(zf ? sn[2] : sn[2] ^ sw, nz[2], zf, acc[2]);
                    o_div_zero <= zf;
                    o_valid    <= 1'b1;
                    state      <= OUT;
                end
                OUT: begin
                    if (i_accept) begin
                        o_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
